// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, types and column-extraction helper
package aes_pkg;

    localparam int AES_NB      = 4;
    localparam int AES_NR      = 10;
    localparam int AES_WORD_W  = 32;
    localparam int AES_STATE_W = 128;

    typedef logic [AES_WORD_W-1:0]  aes_word_t;
    typedef logic [AES_STATE_W-1:0] aes_state_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } arks_state_e;

    // Column 0 lives in the most significant word, matching FIPS-197 byte order.
    function automatic aes_word_t key_col(input aes_state_t key, input logic [1:0] idx);
        return key[AES_STATE_W-1 - AES_WORD_W*int'(idx) -: AES_WORD_W];
    endfunction

endpackage

// File: rtl/add_round_key_stage_if.sv
// rtl/add_round_key_stage_if.sv - column-stream and state-output bundle of the AddRoundKey stage
interface add_round_key_stage_if;
    import aes_pkg::*;

    logic        start;
    aes_word_t   word_in_mix_column;
    logic        word_in_mix_column_vld;
    aes_state_t  round_key;

    aes_word_t   word_out_add_round_key;
    logic        word_out_add_round_key_vld;
    logic [1:0]  col_idx;
    logic [3:0]  round_idx;
    logic        mix_column_off;
    aes_state_t  state_out;
    logic        state_out_vld;
    logic        block_done;

    modport master (
        output start,
        output word_in_mix_column,
        output word_in_mix_column_vld,
        output round_key,
        input  word_out_add_round_key,
        input  word_out_add_round_key_vld,
        input  col_idx,
        input  round_idx,
        input  mix_column_off,
        input  state_out,
        input  state_out_vld,
        input  block_done
    );

    modport slave (
        input  start,
        input  word_in_mix_column,
        input  word_in_mix_column_vld,
        input  round_key,
        output word_out_add_round_key,
        output word_out_add_round_key_vld,
        output col_idx,
        output round_idx,
        output mix_column_off,
        output state_out,
        output state_out_vld,
        output block_done
    );

endinterface

// File: rtl/aes_col_round_cnt.sv
// rtl/aes_col_round_cnt.sv - column/round position tracking and IDLE/RUN control
module aes_col_round_cnt
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       word_vld,
    output logic       accept,
    output logic [1:0] col_sel,
    output logic [3:0] round_idx,
    output logic       round_done,
    output logic       block_last,
    output logic       final_round
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    arks_state_e state_q, state_d;
    logic [1:0]  col_q, col_d;
    logic [3:0]  round_q, round_d;
    logic [3:0]  round_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            round_q <= round_d;
        end
    end

    // start overrides the stored position in the same cycle, so a word arriving
    // with start is always treated as round 0, column 0.
    always_comb begin
        state_d    = state_q;
        col_sel    = start ? 2'd0 : col_q;
        round_sel  = start ? 4'd0 : round_q;
        col_d      = col_sel;
        round_d    = round_sel;
        accept     = word_vld & (start | (state_q == ST_RUN));
        round_done = 1'b0;
        block_last = 1'b0;

        if (start) begin
            state_d = ST_RUN;
        end

        if (accept) begin
            col_d = col_sel + 2'd1;
            if (col_sel == 2'd3) begin
                round_done = 1'b1;
                if (round_sel == LAST_ROUND) begin
                    block_last = 1'b1;
                    round_d    = 4'd0;
                    state_d    = ST_IDLE;
                end else begin
                    round_d = round_sel + 4'd1;
                end
            end
        end
    end

    assign round_idx   = round_q;
    assign final_round = (round_q == LAST_ROUND);

endmodule

// File: rtl/add_round_key_stage.sv
// rtl/add_round_key_stage.sv - per-column AddRoundKey with registered word output and 128-bit state reassembly
module add_round_key_stage
    import aes_pkg::*;
#(
    parameter int NB = AES_NB,
    parameter int NR = AES_NR
) (
    input  logic                 MainClock,
    input  logic                 MainReset,
    add_round_key_stage_if.slave bus
);

    logic       accept;
    logic [1:0] col_sel;
    logic [3:0] round_idx;
    logic       round_done;
    logic       block_last;
    logic       final_round;

    aes_col_round_cnt #(
        .NR (NR)
    ) u_cnt (
        .clk         (MainClock),
        .rst         (MainReset),
        .start       (bus.start),
        .word_vld    (bus.word_in_mix_column_vld),
        .accept      (accept),
        .col_sel     (col_sel),
        .round_idx   (round_idx),
        .round_done  (round_done),
        .block_last  (block_last),
        .final_round (final_round)
    );

    aes_word_t                        result;
    logic [NB-1:0][AES_WORD_W-1:0]    buf_q, buf_d;
    aes_word_t                        word_q, word_d;
    logic                             vld_q, vld_d;
    logic [1:0]                       col_idx_q, col_idx_d;
    aes_state_t                       state_q, state_d;
    logic                             state_vld_q, state_vld_d;
    logic                             done_q, done_d;

    always_ff @(posedge MainClock or posedge MainReset) begin
        if (MainReset) begin
            buf_q       <= '0;
            word_q      <= '0;
            vld_q       <= 1'b0;
            col_idx_q   <= '0;
            state_q     <= '0;
            state_vld_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            word_q      <= word_d;
            vld_q       <= vld_d;
            col_idx_q   <= col_idx_d;
            state_q     <= state_d;
            state_vld_q <= state_vld_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        result      = bus.word_in_mix_column ^ key_col(bus.round_key, col_sel);
        buf_d       = buf_q;
        word_d      = word_q;
        col_idx_d   = col_idx_q;
        state_d     = state_q;
        vld_d       = accept;
        state_vld_d = round_done;
        done_d      = block_last;

        if (accept) begin
            buf_d[col_sel] = result;
            word_d         = result;
            col_idx_d      = col_sel;
        end

        // Built from the next-buffer value so the column written this cycle is included.
        if (round_done) begin
            state_d = {buf_d[0], buf_d[1], buf_d[2], buf_d[3]};
        end
    end

    assign bus.word_out_add_round_key     = word_q;
    assign bus.word_out_add_round_key_vld = vld_q;
    assign bus.col_idx                    = col_idx_q;
    assign bus.round_idx                  = round_idx;
    assign bus.mix_column_off             = final_round;
    assign bus.state_out                  = state_q;
    assign bus.state_out_vld              = state_vld_q;
    assign bus.block_done                 = done_q;

endmodule
